// File: rtl/note_sequencer_pkg.sv
// Package: note_sequencer_pkg
// Purpose : Types and constants shared by the note sequencer and its
//           register-file table. REST_COUNT is also the count the downstream
//           clock divider idles at, so a rest and an idle sequencer look the
//           same to the divider.
package note_sequencer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  // 0.25 s per step at a 50 MHz inclk.
  localparam logic [31:0] TICKS_PER_STEP_DEFAULT = 32'd12500000;

  // Divider count driven while idle or while a rest step plays.
  localparam int REST_COUNT = 1;

endpackage

// File: rtl/note_sequencer_table.sv
// Module : seq_table
// Purpose: DEPTH x CW register file holding divider counts for each step.
//          Synchronous write, every entry resets to REST_COUNT, and the read
//          port is combinational so that a step load on a given edge sees the
//          value stored before any write landing on that same edge.
// Ports  :
//   inclk   in  system clock
//   Reset   in  synchronous active-high reset (all entries -> REST_COUNT)
//   wr_en   in  write strobe
//   wr_addr in  write address
//   wr_data in  write data (0 = rest)
//   rd_addr in  read address
//   rd_data out combinational read data
module seq_table
  import note_sequencer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          inclk,
  input  logic          Reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [CW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [CW-1:0] rd_data
);

  logic [CW-1:0] r_mem [DEPTH];

  always_ff @(posedge inclk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= CW'(REST_COUNT);
      end
    end else if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/note_sequencer.sv
// Module : note_sequencer
// Purpose: Upstream control stage for the programmable clock divider. Plays a
//          sequence of divider counts out of a writable table, holding each
//          step for TICKS_PER_STEP cycles. Entries of 0 are rests (count held
//          at REST_COUNT, tone disabled). Supports play, stop and looping.
// Ports  :
//   inclk         in  system clock
//   Reset         in  synchronous active-high reset
//   wr_en/addr/data in table write port, accepted in any state
//   play          in  start request (level, only acted on in IDLE)
//   stop          in  abort request (level, only acted on in PLAY)
//   loop_en       in  restart at step 0 after the last step
//   seq_len       in  number of steps to play, latched at start
//   div_clk_count out count for the downstream divider
//   tone_en       out high while the current step is a note
//   step_idx      out index of the current step
//   busy          out high in PLAY
//   done          out one-cycle pulse on natural completion
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter logic [31:0] TICKS_PER_STEP = TICKS_PER_STEP_DEFAULT,
  parameter int          DEPTH          = 8,
  parameter int          CW             = 32,
  localparam int         AW             = $clog2(DEPTH),
  localparam int         LW             = AW + 1
) (
  input  logic          inclk,
  input  logic          Reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [CW-1:0] wr_data,
  input  logic          play,
  input  logic          stop,
  input  logic          loop_en,
  input  logic [LW-1:0] seq_len,
  output logic [CW-1:0] div_clk_count,
  output logic          tone_en,
  output logic [AW-1:0] step_idx,
  output logic          busy,
  output logic          done
);

  state_t        r_state,    w_state_next;
  logic [31:0]   r_tick,     w_tick_next;
  logic [LW-1:0] r_len,      w_len_next;
  logic [AW-1:0] r_step_idx, w_idx_next;
  logic [CW-1:0] r_count,    w_count_next;
  logic          r_tone,     w_tone_next;
  logic          r_busy,     w_busy_next;
  logic          r_done,     w_done_next;

  logic          w_load;
  logic [AW-1:0] w_rd_addr;
  logic [CW-1:0] w_rd_data;
  logic [LW-1:0] w_len_clamped;
  logic          w_last_tick;
  logic          w_more_steps;

  seq_table #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_table (
    .inclk   (inclk),
    .Reset   (Reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (w_rd_addr),
    .rd_data (w_rd_data)
  );

  // seq_len can ask for more steps than the table holds; play the whole table.
  assign w_len_clamped = (seq_len > LW'(DEPTH)) ? LW'(DEPTH) : seq_len;
  assign w_last_tick   = (r_tick == TICKS_PER_STEP - 32'd1);
  // r_len >= 1 whenever PLAY is active, so len-1 cannot underflow here.
  assign w_more_steps  = ({1'b0, r_step_idx} < (r_len - LW'(1)));

  always_comb begin
    w_state_next = r_state;
    w_tick_next  = r_tick;
    w_len_next   = r_len;
    w_idx_next   = r_step_idx;
    w_count_next = r_count;
    w_tone_next  = r_tone;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;
    w_load       = 1'b0;
    w_rd_addr    = '0;

    case (r_state)
      IDLE: begin
        if (play && !stop && (seq_len != '0)) begin
          w_state_next = PLAY;
          w_busy_next  = 1'b1;
          w_idx_next   = '0;
          w_tick_next  = 32'd0;
          w_len_next   = w_len_clamped;
          w_load       = 1'b1;
          w_rd_addr    = '0;
        end
      end
      PLAY: begin
        // stop is checked first so it beats a same-cycle step advance.
        if (stop || (w_last_tick && !w_more_steps && !loop_en)) begin
          w_state_next = IDLE;
          w_tick_next  = 32'd0;
          w_len_next   = '0;
          w_idx_next   = '0;
          w_count_next = CW'(REST_COUNT);
          w_tone_next  = 1'b0;
          w_busy_next  = 1'b0;
          w_done_next  = !stop;
        end else if (w_last_tick) begin
          w_tick_next = 32'd0;
          w_load      = 1'b1;
          if (w_more_steps) begin
            w_idx_next = r_step_idx + AW'(1);
            w_rd_addr  = r_step_idx + AW'(1);
          end else begin
            w_idx_next = '0;
            w_rd_addr  = '0;
          end
        end else begin
          w_tick_next = r_tick + 32'd1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    // The table read is combinational, so a write on this same edge is not
    // yet visible and the step loads the old entry.
    if (w_load) begin
      w_count_next = (w_rd_data == '0) ? CW'(REST_COUNT) : w_rd_data;
      w_tone_next  = (w_rd_data != '0);
    end
  end

  always_ff @(posedge inclk) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_tick     <= 32'd0;
      r_len      <= '0;
      r_step_idx <= '0;
      r_count    <= CW'(REST_COUNT);
      r_tone     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_tick     <= w_tick_next;
      r_len      <= w_len_next;
      r_step_idx <= w_idx_next;
      r_count    <= w_count_next;
      r_tone     <= w_tone_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
    end
  end

  assign div_clk_count = r_count;
  assign tone_en       = r_tone;
  assign step_idx      = r_step_idx;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_note_sequencer.sv
// Testbench: tb_note_sequencer
// Purpose  : Scoreboard bench for note_sequencer with TICKS_PER_STEP=4,
//            DEPTH=8. Expected per-cycle outputs are queued as stimulus is
//            driven and compared one cycle at a time after each clock edge.
module tb_note_sequencer;

  localparam int DEPTH = 8;
  localparam int CW    = 32;
  localparam int AW    = 3;
  localparam int LW    = 4;
  localparam int TPS   = 4;

  logic          inclk = 1'b0;
  logic          Reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [CW-1:0] wr_data = '0;
  logic          play = 1'b0;
  logic          stop = 1'b0;
  logic          loop_en = 1'b0;
  logic [LW-1:0] seq_len = '0;
  logic [CW-1:0] div_clk_count;
  logic          tone_en;
  logic [AW-1:0] step_idx;
  logic          busy;
  logic          done;

  note_sequencer #(
    .TICKS_PER_STEP (32'd4),
    .DEPTH          (DEPTH),
    .CW             (CW)
  ) dut (
    .inclk         (inclk),
    .Reset         (Reset),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .play          (play),
    .stop          (stop),
    .loop_en       (loop_en),
    .seq_len       (seq_len),
    .div_clk_count (div_clk_count),
    .tone_en       (tone_en),
    .step_idx      (step_idx),
    .busy          (busy),
    .done          (done)
  );

  always #5 inclk = ~inclk;

  typedef struct {
    logic [CW-1:0] count;
    logic          tone;
    logic [AW-1:0] idx;
    logic          busy;
    logic          done;
    string         tag;
  } exp_t;

  exp_t          sb_q[$];
  logic [CW-1:0] tb_tab [DEPTH];
  int            vectors     = 0;
  int            miscompares = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0d expected=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [CW-1:0] c, input logic t, input logic [AW-1:0] i,
                      input logic b, input logic d, input int n, input string tag);
    exp_t e;
    e.count = c; e.tone = t; e.idx = i; e.busy = b; e.done = d; e.tag = tag;
    for (int k = 0; k < n; k++) sb_q.push_back(e);
  endtask

  // Expected outputs for step s, derived from the bench's shadow of the table.
  task automatic push_step(input int s, input int n, input string tag);
    logic [CW-1:0] v;
    v = tb_tab[s];
    push((v == '0) ? CW'(1) : v, (v != '0), AW'(s), 1'b1, 1'b0, n, tag);
  endtask

  task automatic push_idle(input int n, input string tag);
    push(CW'(1), 1'b0, '0, 1'b0, 1'b0, n, tag);
  endtask

  task automatic push_done(input string tag);
    push(CW'(1), 1'b0, '0, 1'b0, 1'b1, 1, tag);
  endtask

  task automatic tick();
    @(posedge inclk);
    #1;
  endtask

  task automatic compare_now();
    exp_t e;
    if (sb_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_empty got=no_expectation expected=queued_entry @%0t", $time);
    end else begin
      e = sb_q.pop_front();
      check_val({e.tag, ".count"}, div_clk_count, e.count);
      check_val({e.tag, ".tone"},  32'(tone_en),  32'(e.tone));
      check_val({e.tag, ".idx"},   32'(step_idx), 32'(e.idx));
      check_val({e.tag, ".busy"},  32'(busy),     32'(e.busy));
      check_val({e.tag, ".done"},  32'(done),     32'(e.done));
      $display("cycle %0t %s: count=%0d tone=%0b idx=%0d busy=%0b done=%0b",
               $time, e.tag, div_clk_count, tone_en, step_idx, busy, done);
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      compare_now();
    end
  endtask

  task automatic write(input int a, input logic [CW-1:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
    tb_tab[a] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) tb_tab[i] = CW'(1);

    // Reset state
    tick();
    Reset = 1'b0;
    push_idle(1, "reset");
    compare_now();

    // Basic one-shot play with a rest in the middle
    write(0, 32'd10); write(1, 32'd0); write(2, 32'd30);
    seq_len = 4'd3; loop_en = 1'b0; play = 1'b1;
    push_step(0, TPS, "once"); push_step(1, TPS, "once"); push_step(2, TPS, "once");
    push_done("once_done"); push_idle(1, "once_idle");
    run(1); play = 1'b0; run(13);

    // Looping, then loop_en cleared during step 2 of the second pass
    loop_en = 1'b1; play = 1'b1;
    for (int p = 0; p < 5; p++) push_step(p % 3, TPS, "loop");
    run(1); play = 1'b0; run(19);
    push_step(2, TPS, "loop_end"); push_done("loop_done"); push_idle(1, "loop_idle");
    run(1); loop_en = 1'b0; run(5);

    // stop two cycles into step 1, then stop+play together in IDLE
    play = 1'b1;
    push_step(0, TPS, "stop"); push_step(1, 2, "stop");
    run(1); play = 1'b0; run(5);
    stop = 1'b1;
    push_idle(3, "stopped");
    run(1); play = 1'b1; run(2);
    play = 1'b0; stop = 1'b0;

    // Write entry 1 on the edge that loads step 1
    loop_en = 1'b1; play = 1'b1;
    push_step(0, TPS, "wrload");
    push(CW'(1), 1'b0, AW'(1), 1'b1, 1'b0, TPS, "wrload_old");
    push_step(2, TPS, "wrload"); push_step(0, TPS, "wrload");
    push(CW'(77), 1'b1, AW'(1), 1'b1, 1'b0, TPS, "wrload_new");
    push_idle(1, "wrload_stop");
    run(1); play = 1'b0; run(3);
    wr_en = 1'b1; wr_addr = AW'(1); wr_data = 32'd77;
    run(1);
    wr_en = 1'b0; tb_tab[1] = 32'd77;
    run(15);
    stop = 1'b1; loop_en = 1'b0;   // stop on the advance edge
    run(1);
    stop = 1'b0;

    // seq_len = 0 is ignored
    seq_len = 4'd0; play = 1'b1;
    push_idle(3, "len0");
    run(3); play = 1'b0;

    // seq_len = 12 clamps to 8 steps
    for (int i = 3; i < DEPTH; i++) write(i, CW'(100 + i));
    seq_len = 4'd12; play = 1'b1;
    for (int s = 0; s < DEPTH; s++) push_step(s, TPS, "len12");
    push_done("len12_done"); push_idle(1, "len12_idle");
    run(1); play = 1'b0; run(33);

    // Reset mid-step 1, then replay from the reset table
    seq_len = 4'd3; play = 1'b1;
    push_step(0, TPS, "rst"); push_step(1, 2, "rst");
    run(1); play = 1'b0; run(5);
    Reset = 1'b1;
    push_idle(1, "rst_now");
    run(1);
    Reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) tb_tab[i] = CW'(1);
    play = 1'b1;
    push_step(0, TPS, "replay"); push_step(1, TPS, "replay"); push_step(2, TPS, "replay");
    push_done("replay_done"); push_idle(1, "replay_idle");
    run(1); play = 1'b0; run(13);

    check_val("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
